trap_sequencer: RTL
===================

# trap_sequencer

Multi-cycle trap-entry and mret sequencer placed between the writeback stage, the CSR file and fetch. It accepts a trap or mret event from writeback and drives the single CSR write port through the required machine-mode CSR updates (mepc, mcause, mstatus), one per cycle. It then issues a fetch redirect. While idle, the CSR write port is shared with writeback's ordinary CSR-instruction writes, and the block holds the pipeline flushed for the whole sequence.

## Interface
- `CSR_MEPC`, 12'h341, mepc address
- `CSR_MCAUSE`, 12'h342, mcause address
- `CSR_MSTATUS`, 12'h300, mstatus address
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `traped`  in  1  trap request from writeback
- `mret`  in  1  mret request from writeback
- `ecp`  in  32  exception PC from writeback
- `ecause`  in  4  cause code from writeback
- `interupt`  in  1  cause is an interrupt
- `wb_csr_write`  in  1  writeback CSR-instruction write enable
- `wb_csr_address`  in  12  writeback CSR address
- `wb_csr_data`  in  32  writeback CSR data
- `mtvec`  in  32  current mtvec, from the CSR file
- `mepc`  in  32  current mepc, from the CSR file
- `mstatus`  in  32  current mstatus, from the CSR file
- `csr_write`  out  1  CSR write enable
- `csr_address`  out  12  CSR write address
- `csr_data`  out  32  CSR write data
- `redirect`  out  1  fetch redirect strobe
- `redirect_pc`  out  32  fetch target
- `busy`  out  1  to hazard unit: flush and stall the pipeline

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, REDIRECT.
- **IDLE**
  - `traped`=1: latch `ecp`, `ecause` and `interupt`; go to W_MEPC.
  - Else `mret`=1: latch `mepc` into the target register; go to R_MSTATUS.
  - If `traped` and `mret` are both 1, the trap wins and `mret` is dropped.
- **W_MEPC**: write `CSR_MEPC` with `{ecp_q[31:2],2'b00}`.
- **W_MCAUSE**: write `CSR_MCAUSE` with `{interupt_q,27'b0,ecause_q}`.
- **W_MSTATUS**: write `CSR_MSTATUS` with `mstatus` modified as follows; go to REDIRECT.
  - bit7 (MPIE) = mstatus[3]
  - bit3 (MIE) = 0
  - bits12:11 (MPP) = 2'b11
- **R_MSTATUS**: write `CSR_MSTATUS` with `mstatus` modified as follows; go to REDIRECT.
  - bit3 = mstatus[7]
  - bit7 = 1
  - bits12:11 = 2'b11
- **REDIRECT**: `redirect`=1 with `redirect_pc` = the latched target; go to IDLE.
  - Trap target = `{mtvec[31:2],2'b00}`; see Configuration for the vectored case.
  - mret target = `{mepc_q[31:2],2'b00}`.
- CSR port arbitration:
  - In IDLE, the port passes through `wb_csr_*` gated by `!traped && !mret`.
  - In all other states the sequencer owns the port; writeback writes are discarded, never queued.
- `busy` = (state != IDLE) || `traped` || `mret`. It is combinational so the event cycle is flushed too.
- Any `traped` or `mret` arriving outside IDLE is ignored.
- Trap target arithmetic is 32-bit, modulo 2^32 (wraps).

## Timing
- Trap accepted at edge T:
  - mepc write in cycle T+1
  - mcause write in T+2
  - mstatus write in T+3
  - `redirect` in T+4
  - back in IDLE, able to accept a new event, at T+5
- mret accepted at edge T: mstatus write in T+1, `redirect` in T+2, IDLE at T+3.
- `mtvec` and `mstatus` are sampled in the cycle that uses them, not at acceptance.
- `redirect` is a single-cycle pulse.
- Reset (asynchronous, while `reset_n`=0):
  - state = IDLE; `ecp_q`, `ecause_q`, `interupt_q` and the target register = 0.
  - `redirect`=0 and `redirect_pc`=0.
  - `csr_write` follows the IDLE pass-through; with idle inputs this is 0.
  - `busy` follows `traped`/`mret`; with idle inputs this is 0.
- Reset mid-sequence aborts immediately. Remaining CSR writes and the redirect are not issued.

## Configuration
- `TRAP_VECTORED_EN` defined: when `interupt_q`=1 and `mtvec[1:0]`=2'b01, the trap target is `{mtvec[31:2],2'b00} + 4*ecause_q`.
- Undefined: mtvec mode bits are ignored and all traps go to `{mtvec[31:2],2'b00}`.

## Test plan
- Exception trap:
  - Stimulus: `traped`=1, `ecp`=32'h0000_1234, `ecause`=2, `interupt`=0, `mstatus`=32'h8, `mtvec`=32'h100.
  - Required: writes 341←32'h1234, 342←32'h2, 300←32'h1880 in successive cycles, then `redirect` with pc 32'h100.
- Vectored timer interrupt with `TRAP_VECTORED_EN`:
  - Stimulus: `mtvec`=32'h201, `ecause`=7, `interupt`=1.
  - Required: mcause write 32'h8000_0007; `redirect_pc`=32'h21C. Without the macro, `redirect_pc`=32'h200.
- mret:
  - Stimulus: `mepc`=32'h0000_0ABF, `mstatus`=32'h80.
  - Required: write 300←32'h1888 in T+1; `redirect_pc`=32'hABC in T+2.
- Simultaneous and arbitration:
  - Stimulus: `traped` and `mret` high together; `wb_csr_write`=1 during W_MCAUSE.
  - Required: trap sequence only; the writeback write never appears on the port.
  - Stimulus: `wb_csr_write`=1 in IDLE.
  - Required: it passes through unchanged in the same cycle.
- Reset mid-sequence:
  - Stimulus: `reset_n`=0 during W_MCAUSE.
  - Required: `csr_write`=0, `redirect`=0 and `busy`=0 at once. After release the block is idle and accepts a new trap with the full 5-cycle latency.

Source files
------------

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap-entry / mret CSR write sequencer with fetch redirect
// Optional vectored interrupt targets via the TRAP_VECTORED_EN macro.
module trap_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        traped,
   input  logic        mret,
   input  logic [31:0] ecp,
   input  logic [3:0]  ecause,
   input  logic        interupt,
   input  logic        wb_csr_write,
   input  logic [11:0] wb_csr_address,
   input  logic [31:0] wb_csr_data,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic [31:0] mstatus,
   output logic        csr_write,
   output logic [11:0] csr_address,
   output logic [31:0] csr_data,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      R_MSTATUS,
      REDIRECT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ecp_q, ecp_d;
   logic [3:0]  ecause_q, ecause_d;
   logic        interupt_q, interupt_d;
   logic [31:0] target_q, target_d;
   logic        is_trap_q, is_trap_d;
   logic [31:0] trap_pc;
   logic [31:0] trap_mstatus;
   logic [31:0] mret_mstatus;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ecp_q      <= '0;
         ecause_q   <= '0;
         interupt_q <= 1'b0;
         target_q   <= '0;
         is_trap_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ecp_q      <= ecp_d;
         ecause_q   <= ecause_d;
         interupt_q <= interupt_d;
         target_q   <= target_d;
         is_trap_q  <= is_trap_d;
      end
   end

   // mtvec is sampled live in the REDIRECT cycle, so the trap target is never registered.
   always_comb begin
      trap_pc = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
      if (interupt_q && (mtvec[1:0] == 2'b01))
         trap_pc = (mtvec & 32'hFFFF_FFFC) + {26'b0, ecause_q, 2'b00};
`endif
   end

   always_comb begin
      trap_mstatus         = mstatus;
      trap_mstatus[7]      = mstatus[3];
      trap_mstatus[3]      = 1'b0;
      trap_mstatus[12:11]  = 2'b11;
      mret_mstatus         = mstatus;
      mret_mstatus[3]      = mstatus[7];
      mret_mstatus[7]      = 1'b1;
      mret_mstatus[12:11]  = 2'b11;
   end

   always_comb begin
      state_d     = state_q;
      ecp_d       = ecp_q;
      ecause_d    = ecause_q;
      interupt_d  = interupt_q;
      target_d    = target_q;
      is_trap_d   = is_trap_q;
      csr_write   = 1'b0;
      csr_address = '0;
      csr_data    = '0;
      redirect    = 1'b0;
      redirect_pc = '0;

      case (state_q)
         IDLE: begin
            csr_write   = wb_csr_write && !traped && !mret;
            csr_address = wb_csr_address;
            csr_data    = wb_csr_data;
            if (traped) begin
               ecp_d      = ecp;
               ecause_d   = ecause;
               interupt_d = interupt;
               is_trap_d  = 1'b1;
               state_d    = W_MEPC;
            end else if (mret) begin
               target_d   = mepc;
               is_trap_d  = 1'b0;
               state_d    = R_MSTATUS;
            end
         end
         W_MEPC: begin
            csr_write   = 1'b1;
            csr_address = CSR_MEPC;
            csr_data    = ecp_q & 32'hFFFF_FFFC;
            state_d     = W_MCAUSE;
         end
         W_MCAUSE: begin
            csr_write   = 1'b1;
            csr_address = CSR_MCAUSE;
            csr_data    = {interupt_q, 27'b0, ecause_q};
            state_d     = W_MSTATUS;
         end
         W_MSTATUS: begin
            csr_write   = 1'b1;
            csr_address = CSR_MSTATUS;
            csr_data    = trap_mstatus;
            state_d     = REDIRECT;
         end
         R_MSTATUS: begin
            csr_write   = 1'b1;
            csr_address = CSR_MSTATUS;
            csr_data    = mret_mstatus;
            state_d     = REDIRECT;
         end
         REDIRECT: begin
            redirect    = 1'b1;
            redirect_pc = is_trap_q ? trap_pc : (target_q & 32'hFFFF_FFFC);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE) || traped || mret;

endmodule
